bus_demux2: RTL and testbench
=============================

# bus_demux2

Address-steered 1-to-2 request router for the CPU data-memory port. It takes one master-side request stream from the MEM stage and forwards each transaction to exactly one of two slave ports: slave 0 is RAM, slave 1 is the MMIO window. It tracks the single outstanding transaction and steers the matching response back to the master, making it the return-path counterpart of the result-select muxes. An optional watchdog aborts transactions whose slave never responds.

## Interface
- WIDTH, 32, data and address width
- S1_BASE, 32'hBFAF_0000, MMIO window base address
- S1_MASK, 32'hFFFF_0000, address bits compared against S1_BASE
- TIMEOUT, 255, watchdog limit in cycles, range 1..255 (used only with BUS_DEMUX_TIMEOUT_EN)

Ports:
- clk  input  1  single clock; all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- m_req  input  1  master request valid
- m_we  input  1  1 = write, 0 = read
- m_addr  input  WIDTH  byte address
- m_wdata  input  WIDTH  write data
- m_wstrb  input  4  byte enables
- m_gnt  output  1  request accepted this cycle
- m_rvalid  output  1  response valid, one-cycle pulse
- m_rdata  output  WIDTH  read data; 0 for writes
- m_err  output  1  sticky timeout flag, cleared only by reset
- s0_req/s1_req  output  1  slave request
- s0_we/s1_we, s0_addr/s1_addr, s0_wdata/s1_wdata, s0_wstrb/s1_wstrb  output  as master  forwarded fields
- s0_gnt/s1_gnt  input  1  slave accepted
- s0_rvalid/s1_rvalid  input  1  slave response (read data or write ack)
- s0_rdata/s1_rdata  input  WIDTH  slave read data

## Operation
- Decode: sel = ((m_addr & S1_MASK) == (S1_BASE & S1_MASK)). sel = 1 routes to s1, sel = 0 routes to s0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - s{sel}_req = m_req; the other slave's req = 0.
  - Fields go to both slaves unconditionally.
  - m_gnt = m_req & s{sel}_gnt.
  - On m_gnt: latch sel into cur, latch m_we, clear the watchdog, and go to WAIT.
- WAIT:
  - All s*_req = 0 and m_gnt = 0.
  - On s{cur}_rvalid: latch rdata (0 if write) and go to RESP.
  - rvalid from the non-selected slave is ignored.
- RESP:
  - m_rvalid = 1 for exactly one cycle, m_rdata holds the latched value, then go to IDLE.
  - m_gnt = 0 in RESP, so back-to-back transactions take at least 3 cycles.
- m_rdata holds its last value outside RESP.
- Reset (async, any state):
  - State goes to IDLE; m_rvalid, m_rdata, m_err, cur and the watchdog go to 0.
  - All s*_req and m_gnt are forced to 0 while resetn is low.
  - An in-flight transaction is dropped without a response; a late slave rvalid after reset is ignored, because the FSM is in IDLE.

## Timing
- Request path is combinational: m_req to s*_req, and s*_gnt to m_gnt.
- Response latency: s_rvalid in cycle N gives m_rvalid in cycle N+1. The response is registered, with no combinational path from s*_rvalid to m_rvalid.
- Minimum transaction: gnt in cycle 0, slave rvalid in cycle 1, m_rvalid in cycle 2, next gnt in cycle 3.
- Slave rvalid in the same cycle as gnt is not allowed; slaves respond no earlier than the cycle after gnt.
- Master holds m_req and its fields stable until m_gnt.

## Configuration
- BUS_DEMUX_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in WAIT.
  - When the count reaches TIMEOUT with no s{cur}_rvalid, go to RESP with m_rdata = 32'hDEAD_BEEF and set m_err = 1.
  - If slave rvalid and timeout occur in the same cycle, slave rvalid wins and m_err is unchanged.
- BUS_DEMUX_TIMEOUT_EN undefined: no counter; WAIT is left only on slave rvalid; m_err is tied to 0.

## Test plan
- Reset: hold resetn = 0 with m_req = 1 -> s0_req = s1_req = 0, m_gnt = 0, m_rvalid = 0, m_err = 0.
- RAM read:
  - Stimulus: m_addr = 32'h0000_1000, s0_gnt = 1, s0 returns 32'h1234_5678 one cycle later.
  - Response: s0_req = 1, s1_req = 0, m_gnt in cycle 0, m_rvalid with 32'h1234_5678 in cycle 2.
- MMIO write:
  - Stimulus: m_addr = 32'hBFAF_F000, m_we = 1, m_wstrb = 4'hF, s1_gnt held low 3 cycles then high.
  - Response: m_gnt asserts only when s1_gnt asserts; s1 ack gives m_rvalid with m_rdata = 0.
- Spurious response: in WAIT for s0, pulse s1_rvalid with 32'hFFFF_FFFF -> no m_rvalid; the later s0 response is delivered.
- Timeout (macro on, TIMEOUT = 4): slave never responds -> m_rvalid with 32'hDEAD_BEEF 5 cycles after gnt, m_err = 1 and stays 1.
- Reset mid-WAIT: assert resetn = 0 during WAIT, release, then the slave rvalid arrives -> no m_rvalid; the next request is accepted normally.

Source files
------------

// File: rtl/bus_demux2.sv
// bus_demux2: address-steered 1-to-2 data-memory request router (RAM / MMIO) with response return.
// Optional watchdog abort enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux2 #(
  parameter int unsigned        WIDTH   = 32,
  parameter logic [WIDTH-1:0]   S1_BASE = 32'hBFAF_0000,
  parameter logic [WIDTH-1:0]   S1_MASK = 32'hFFFF_0000,
  parameter int unsigned        TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [WIDTH-1:0] m_addr,
  input  logic [WIDTH-1:0] m_wdata,
  input  logic [3:0]       m_wstrb,
  output logic             m_gnt,
  output logic             m_rvalid,
  output logic [WIDTH-1:0] m_rdata,
  output logic             m_err,
  output logic             s0_req,
  output logic             s0_we,
  output logic [WIDTH-1:0] s0_addr,
  output logic [WIDTH-1:0] s0_wdata,
  output logic [3:0]       s0_wstrb,
  input  logic             s0_gnt,
  input  logic             s0_rvalid,
  input  logic [WIDTH-1:0] s0_rdata,
  output logic             s1_req,
  output logic             s1_we,
  output logic [WIDTH-1:0] s1_addr,
  output logic [WIDTH-1:0] s1_wdata,
  output logic [3:0]       s1_wstrb,
  input  logic             s1_gnt,
  input  logic             s1_rvalid,
  input  logic [WIDTH-1:0] s1_rdata
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_demux2: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             cur_q, cur_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             sel;
  logic             rv_cur;
  logic [WIDTH-1:0] rd_cur;

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  assign sel = ((m_addr & S1_MASK) == (S1_BASE & S1_MASK));

  assign s0_we    = m_we;
  assign s0_addr  = m_addr;
  assign s0_wdata = m_wdata;
  assign s0_wstrb = m_wstrb;
  assign s1_we    = m_we;
  assign s1_addr  = m_addr;
  assign s1_wdata = m_wdata;
  assign s1_wstrb = m_wstrb;

  assign rv_cur = cur_q ? s1_rvalid : s0_rvalid;
  assign rd_cur = cur_q ? s1_rdata  : s0_rdata;

  assign m_rdata  = rdata_q;
  assign m_rvalid = (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    s0_req  = 1'b0;
    s1_req  = 1'b0;
    m_gnt   = 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // resetn gating keeps the request path quiet while reset is held
        s0_req = resetn & m_req & ~sel;
        s1_req = resetn & m_req & sel;
        m_gnt  = resetn & m_req & (sel ? s1_gnt : s0_gnt);
        if (m_gnt) begin
          state_d = S_WAIT;
          cur_d   = sel;
          we_d    = m_we;
`ifdef BUS_DEMUX_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (rv_cur) begin
          rdata_d = we_q ? '0 : rd_cur;
          state_d = S_RESP;
        end
`ifdef BUS_DEMUX_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          rdata_d = WIDTH'(32'hDEAD_BEEF);
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cur_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_DEMUX_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign m_err = err_q;
`else
  assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_demux2.sv
// tb_bus_demux2: directed vector table plus hand sequences for bus_demux2 (reset, routing,
// spurious response, watchdog/long wait, reset during WAIT).
module tb_bus_demux2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic        s0_req, s0_we, s0_gnt, s0_rvalid;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s1_req, s1_we, s1_gnt, s1_rvalid;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  bus_demux2 #(.WIDTH(32), .S1_BASE(32'hBFAF_0000), .S1_MASK(32'hFFFF_0000), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_gnt(s0_gnt), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
    .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_gnt(s1_gnt), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] srdata;
    logic        sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge, DUT in IDLE.
  task automatic txn(input vec_t v, input logic exp_err);
    logic [1:0] route;
    route   = v.sel ? 2'b10 : 2'b01;
    m_req   = 1'b1;
    m_we    = v.we;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_wstrb = v.wstrb;
    s0_gnt  = v.sel;
    s1_gnt  = !v.sel;
    for (int i = 0; i < v.gnt_dly; i++) begin
      @(negedge clk);
      chk("gnt_wait", {127'd0, m_gnt}, 128'd0);
      chk("req_route_wait", {126'd0, s1_req, s0_req}, {126'd0, route});
      step();
    end
    s0_gnt = !v.sel;
    s1_gnt = v.sel;
    @(negedge clk);
    chk("gnt", {127'd0, m_gnt}, 128'd1);
    chk("req_route", {126'd0, s1_req, s0_req}, {126'd0, route});
    chk("fwd_s0", {59'd0, s0_we, s0_addr, s0_wdata, s0_wstrb}, {59'd0, v.we, v.addr, v.wdata, v.wstrb});
    chk("fwd_s1", {59'd0, s1_we, s1_addr, s1_wdata, s1_wstrb}, {59'd0, v.we, v.addr, v.wdata, v.wstrb});
    step();
    // keep requesting with both slaves granting: WAIT/RESP must not forward or grant
    s0_gnt = 1'b1;
    s1_gnt = 1'b1;
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clk);
      chk("wait_quiet", {124'd0, m_rvalid, m_gnt, s1_req, s0_req}, 128'd0);
      step();
    end
    if (v.sel) begin s1_rvalid = 1'b1; s1_rdata = v.srdata; end
    else       begin s0_rvalid = 1'b1; s0_rdata = v.srdata; end
    @(negedge clk);
    chk("rvalid_registered", {124'd0, m_rvalid, m_gnt, s1_req, s0_req}, 128'd0);
    step();
    s0_rvalid = 1'b0;
    s1_rvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", {127'd0, m_rvalid}, 128'd1);
    chk("rdata", {96'd0, m_rdata}, {96'd0, v.exp_rdata});
    chk("err", {127'd0, m_err}, {127'd0, exp_err});
    chk("resp_quiet", {125'd0, m_gnt, s1_req, s0_req}, 128'd0);
    step();
    m_req  = 1'b0;
    s0_gnt = 1'b0;
    s1_gnt = 1'b0;
  endtask

  initial begin
    vec_t v;
    //         we    addr          wdata         strb  gd rd srdata        sel   exp_rdata
    vt[0] = '{1'b0, 32'h0000_1000, 32'h0,        4'h0, 0, 0, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vt[1] = '{1'b1, 32'hBFAF_F000, 32'hA5A5_A5A5, 4'hF, 3, 0, 32'h55AA_55AA, 1'b1, 32'h0};
    vt[2] = '{1'b0, 32'hBFAF_0004, 32'h0,        4'hF, 0, 1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001};
    vt[3] = '{1'b0, 32'hBFAE_FFFC, 32'h0,        4'hF, 0, 2, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
    vt[4] = '{1'b0, 32'hBFB0_0000, 32'h0,        4'hF, 1, 3, 32'h1111_2222, 1'b0, 32'h1111_2222};
    vt[5] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'h3, 0, 0, 32'h9999_9999, 1'b0, 32'h0};
    vt[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'hF, 2, 0, 32'h8000_0001, 1'b0, 32'h8000_0001};
    vt[7] = '{1'b0, 32'hBFAF_FFFF, 32'h0,        4'h1, 0, 1, 32'h7E57_0007, 1'b1, 32'h7E57_0007};

    resetn    = 1'b0;
    m_req     = 1'b1;
    m_we      = 1'b0;
    m_addr    = 32'hBFAF_0000;
    m_wdata   = 32'h0;
    m_wstrb   = 4'hF;
    s0_gnt    = 1'b1;
    s1_gnt    = 1'b1;
    s0_rvalid = 1'b0;
    s1_rvalid = 1'b0;
    s0_rdata  = 32'h0;
    s1_rdata  = 32'h0;

    // reset held with a live request to either slave
    @(negedge clk);
    chk("rst_quiet_s1", {123'd0, s0_req, s1_req, m_gnt, m_rvalid, m_err}, 128'd0);
    m_addr = 32'h0000_1000;
    @(negedge clk);
    chk("rst_quiet_s0", {123'd0, s0_req, s1_req, m_gnt, m_rvalid, m_err}, 128'd0);
    chk("rst_rdata", {96'd0, m_rdata}, 128'd0);
    m_req  = 1'b0;
    s0_gnt = 1'b0;
    s1_gnt = 1'b0;
    resetn = 1'b1;
    step();

    for (int i = 0; i < 8; i++) txn(vt[i], 1'b0);

    @(negedge clk);
    chk("idle_after_resp", {127'd0, m_rvalid}, 128'd0);
    chk("rdata_hold", {96'd0, m_rdata}, {96'd0, vt[7].exp_rdata});
    step();

    // spurious response from the non-selected slave during WAIT
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_3000; s0_gnt = 1'b1;
    @(negedge clk);
    chk("spur_gnt", {127'd0, m_gnt}, 128'd1);
    step();
    m_req = 1'b0; s0_gnt = 1'b0;
    s1_rvalid = 1'b1; s1_rdata = 32'hFFFF_FFFF;
    step();
    s1_rvalid = 1'b0;
    @(negedge clk);
    chk("spur_no_rvalid", {127'd0, m_rvalid}, 128'd0);
    chk("spur_rdata_hold", {96'd0, m_rdata}, {96'd0, vt[7].exp_rdata});
    s0_rvalid = 1'b1; s0_rdata = 32'h4242_4242;
    step();
    s0_rvalid = 1'b0;
    @(negedge clk);
    chk("spur_real_rvalid", {127'd0, m_rvalid}, 128'd1);
    chk("spur_real_rdata", {96'd0, m_rdata}, 128'h4242_4242);
    step();

`ifdef BUS_DEMUX_TIMEOUT_EN
    // slave never answers: abort after TIMEOUT=4 WAIT cycles
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'hBFAF_0100; s1_gnt = 1'b1;
    @(negedge clk);
    chk("to_gnt", {127'd0, m_gnt}, 128'd1);
    step();
    m_req = 1'b0; s1_gnt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to_wait", {126'd0, m_rvalid, m_err}, 128'd0);
      step();
    end
    @(negedge clk);
    chk("to_rvalid", {127'd0, m_rvalid}, 128'd1);
    chk("to_rdata", {96'd0, m_rdata}, 128'hDEAD_BEEF);
    chk("to_err", {127'd0, m_err}, 128'd1);
    step();
    txn(vt[0], 1'b1);
    @(negedge clk);
    chk("to_err_sticky", {127'd0, m_err}, 128'd1);
    step();
`else
    // without the watchdog a slow slave simply stretches WAIT
    v = vt[3];
    v.rsp_dly = 20;
    txn(v, 1'b0);
`endif

    // reset while in WAIT, then a late slave response must be dropped
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_2000; s0_gnt = 1'b1;
    @(negedge clk);
    chk("rw_gnt", {127'd0, m_gnt}, 128'd1);
    step();
    m_req = 1'b0; s0_gnt = 1'b0;
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("rw_rst_state", {94'd0, m_rvalid, m_err, m_rdata}, 128'd0);
    #1;
    resetn = 1'b1;
    step();
    s0_rvalid = 1'b1; s0_rdata = 32'h7777_7777;
    step();
    s0_rvalid = 1'b0;
    @(negedge clk);
    chk("rw_late_drop", {95'd0, m_rvalid, m_rdata}, 128'd0);
    step();
    txn(vt[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
